// File: rtl/stacker_engine.sv
// stacker_engine: stacker game core. A block bounces across the active row,
// a drop freezes it, and the overhang against the row below is trimmed off.
// Renders the playfield from hCount/vCount into a registered rgb.
module stacker_engine #(
  parameter int ROWS      = 10,
  parameter int COLS      = 16,
  parameter int START_W   = 4,
  parameter int CELL_PX   = 40,
  parameter int ORIGIN_X  = 144,
  parameter int ORIGIN_Y  = 35,
  parameter int TICK_INIT = 5,
  parameter int TICK_DEC  = 1,
  parameter int TICK_MIN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_drop,
  input  logic [9:0]                  hCount,
  input  logic [9:0]                  vCount,
  output logic [11:0]                 rgb,
  output logic [7:0]                  score,
  output logic [$clog2(ROWS+1)-1:0]   level,
  output logic                        game_over,
  output logic                        win
);
  localparam int CW    = $clog2(COLS+1);
  localparam int CW1   = CW + 1;
  localparam int RW    = $clog2(ROWS+1);
  localparam int PW    = $clog2(TICK_INIT+1);
  localparam int SW    = (CW1 > 9) ? CW1 : 9;
  localparam int DEC_I = (TICK_DEC > TICK_INIT) ? TICK_INIT : TICK_DEC;

  localparam logic [CW-1:0] COLS_C  = CW'(COLS);
  localparam logic [CW:0]   COLS_S  = CW1'(COLS);
  localparam logic [CW-1:0] START_C = CW'(START_W);
  localparam logic [RW-1:0] ROWS_C  = RW'(ROWS);
  localparam logic [PW-1:0] INIT_C  = PW'(TICK_INIT);
  localparam logic [PW-1:0] DEC_C   = PW'(DEC_I);
  localparam logic [PW-1:0] MIN_C   = PW'(TICK_MIN);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_TRIM, S_ADV, S_LOSE, S_WIN} state_t;

  state_t                  state_q, state_d;
  logic                    btn_q, armed_q;
  logic [RW-1:0]           row_q, row_d, level_q, level_d;
  logic [CW-1:0]           left_q, left_d, width_q, width_d;
  logic                    dir_q, dir_d;
  logic [PW-1:0]           period_q, period_d, tick_q, tick_d;
  logic [ROWS-1:0][CW-1:0] rl_q, rl_d, rw_q, rw_d;
  logic [7:0]              score_q, score_d;
  logic [11:0]             rgb_q, pix;

  // armed_q blocks a start from a button still held across reset: a press
  // only counts once the button has been seen low after reset release.
  logic drop_e;
  assign drop_e = btn_drop & ~btn_q & armed_q;

  // Trim arithmetic against the row below (row 0 keeps the block as is).
  logic [RW-1:0] prev_idx;
  logic [CW-1:0] pl, pw, lo, trim_l, trim_w;
  logic [CW:0]   sum, psum, hi;
  logic [SW-1:0] sc_sum;
  logic [7:0]    score_sat;
  logic [PW-1:0] per_next;
  logic          no_overlap;

  assign prev_idx   = (row_q == '0) ? '0 : row_q - RW'(1);
  assign pl         = rl_q[prev_idx];
  assign pw         = rw_q[prev_idx];
  assign sum        = {1'b0, left_q} + {1'b0, width_q};
  assign psum       = {1'b0, pl} + {1'b0, pw};
  assign lo         = (left_q > pl) ? left_q : pl;
  assign hi         = (sum < psum) ? sum : psum;
  assign no_overlap = (row_q != '0) && (hi <= {1'b0, lo});
  assign trim_l     = (row_q == '0) ? left_q : lo;
  assign trim_w     = (row_q == '0) ? width_q : CW'(hi - {1'b0, lo});
  assign sc_sum     = SW'(score_q) + SW'(trim_w);
  assign score_sat  = (sc_sum > SW'(255)) ? 8'hFF : sc_sum[7:0];
  assign per_next   = (period_q > DEC_C && (period_q - DEC_C) > MIN_C) ? period_q - DEC_C : MIN_C;

  // Next-state and datapath updates for the game FSM.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    left_d   = left_q;
    width_d  = width_q;
    dir_d    = dir_q;
    period_d = period_q;
    tick_d   = tick_q;
    rl_d     = rl_q;
    rw_d     = rw_q;
    score_d  = score_q;
    level_d  = level_q;
    case (state_q)
      S_IDLE: if (drop_e) begin
        state_d  = S_MOVE;
        row_d    = '0;
        left_d   = '0;
        width_d  = START_C;
        dir_d    = 1'b1;
        period_d = INIT_C;
        tick_d   = '0;
      end
      S_MOVE: begin
        if (drop_e) begin
          state_d = S_TRIM;  // a coincident step is discarded
        end else if (tick_q == period_q - PW'(1)) begin
          tick_d = '0;
          if (width_q != COLS_C) begin
            if (dir_q) begin
              if (sum < COLS_S) left_d = left_q + CW'(1);
              else begin
                dir_d = 1'b0;
                if (left_q != '0) left_d = left_q - CW'(1);
              end
            end else begin
              if (left_q != '0) left_d = left_q - CW'(1);
              else begin
                dir_d = 1'b1;
                if (sum < COLS_S) left_d = left_q + CW'(1);
              end
            end
          end
        end else begin
          tick_d = tick_q + PW'(1);
        end
      end
      S_TRIM: begin
        if (no_overlap) state_d = S_LOSE;
        else begin
          rl_d[row_q] = trim_l;
          rw_d[row_q] = trim_w;
          score_d     = score_sat;
          state_d     = S_ADV;
        end
      end
      S_ADV: begin
        row_d   = row_q + RW'(1);
        level_d = row_q + RW'(1);
        if (row_q + RW'(1) == ROWS_C) state_d = S_WIN;
        else begin
          left_d   = '0;
          width_d  = rw_q[row_q];
          dir_d    = 1'b1;
          tick_d   = '0;
          period_d = per_next;
          state_d  = S_MOVE;
        end
      end
      S_LOSE, S_WIN: if (drop_e) begin
        rl_d    = '0;
        rw_d    = '0;
        score_d = '0;
        level_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Game datapath and button edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= 1'b0; armed_q <= 1'b0;
      row_q <= '0; left_q <= '0; width_q <= '0; dir_q <= 1'b1;
      period_q <= '0; tick_q <= '0;
      rl_q <= '0; rw_q <= '0; score_q <= '0; level_q <= '0;
    end else begin
      btn_q <= btn_drop; armed_q <= armed_q | ~btn_drop;
      row_q <= row_d; left_q <= left_d; width_q <= width_d; dir_q <= dir_d;
      period_q <= period_d; tick_q <= tick_d;
      rl_q <= rl_d; rw_q <= rw_d; score_q <= score_d; level_q <= level_d;
    end
  end

  // Map the pixel to a grid cell (11-bit compares so nothing wraps).
  logic [10:0]   hx, vy;
  logic          col_hit, row_hit, stored_hit, active_hit;
  logic [CW-1:0] col;
  logic [RW-1:0] prow;
  logic [11:0]   bg;
  assign hx = {1'b0, hCount};
  assign vy = {1'b0, vCount};

  always_comb begin
    col_hit = 1'b0; col = '0; row_hit = 1'b0; prow = '0;
    for (int c = 0; c < COLS; c++)
      if (hx >= 11'(ORIGIN_X + c*CELL_PX) && hx < 11'(ORIGIN_X + (c+1)*CELL_PX)) begin
        col_hit = 1'b1; col = CW'(c);
      end
    for (int r = 0; r < ROWS; r++)
      if (vy >= 11'(ORIGIN_Y + (ROWS-1-r)*CELL_PX) && vy < 11'(ORIGIN_Y + (ROWS-r)*CELL_PX)) begin
        row_hit = 1'b1; prow = RW'(r);
      end
  end

  assign bg = (state_q == S_LOSE) ? 12'h400 : (state_q == S_WIN) ? 12'h0F0 : 12'h000;
  assign stored_hit = row_hit && col_hit && (col >= rl_q[prow]) &&
                      ({1'b0, col} < {1'b0, rl_q[prow]} + {1'b0, rw_q[prow]});
  assign active_hit = row_hit && col_hit && (state_q == S_MOVE || state_q == S_TRIM) &&
                      (prow == row_q) && (col >= left_q) && ({1'b0, col} < sum);
  assign pix = active_hit ? 12'hFFF : stored_hit ? 12'hF00 : bg;

  // Register the pixel colour (one cycle behind hCount/vCount).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= pix;
  end

  assign rgb       = rgb_q;
  assign score     = score_q;
  assign level     = level_q;
  assign game_over = (state_q == S_LOSE);
  assign win       = (state_q == S_WIN);
endmodule

// File: tb/tb_stacker_engine.sv
// tb_stacker_engine: directed scenarios plus random button/pixel traffic,
// checked against a behavioural game model; a ROWS=3 instance covers winning.
module tb_stacker_engine;
  localparam int ROWS = 10, COLS = 16, START_W = 4, CELL_PX = 40;
  localparam int OX = 144, OY = 35, TICK_INIT = 5, TICK_DEC = 1, TICK_MIN = 1;
  localparam int LW = $clog2(ROWS+1);
  localparam int P_IDLE = 0, P_MOVE = 1, P_TRIM = 2, P_ADV = 3, P_LOSE = 4, P_WIN = 5;

  logic          clk = 1'b0, rst = 1'b1, btn_drop = 1'b0;
  logic [9:0]    hCount = '0, vCount = '0;
  logic [11:0]   rgb;
  logic [7:0]    score;
  logic [LW-1:0] level;
  logic          game_over, win;

  logic        btn3 = 1'b0;
  logic [9:0]  h3 = '0, v3 = '0;
  logic [11:0] rgb3;
  logic [7:0]  score3;
  logic [1:0]  level3;
  logic        go3, win3;

  int n_chk = 0, n_err = 0;

  stacker_engine dut (
    .clk(clk), .rst(rst), .btn_drop(btn_drop), .hCount(hCount), .vCount(vCount),
    .rgb(rgb), .score(score), .level(level), .game_over(game_over), .win(win));

  stacker_engine #(.ROWS(3), .TICK_INIT(3)) dut3 (
    .clk(clk), .rst(rst), .btn_drop(btn3), .hCount(h3), .vCount(v3),
    .rgb(rgb3), .score(score3), .level(level3), .game_over(go3), .win(win3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph, m_row, m_width, m_period, m_entry, m_left, m_score, m_level, m_cyc;
  int m_pl[ROWS], m_pw[ROWS];
  bit m_btnq, m_armed;
  logic [11:0] m_rgb;

  task automatic model_reset();
    m_ph = P_IDLE; m_row = 0; m_width = 0; m_period = 0; m_entry = 0; m_left = 0;
    m_score = 0; m_level = 0; m_btnq = 0; m_armed = 0;
    for (int i = 0; i < ROWS; i++) begin m_pl[i] = 0; m_pw[i] = 0; end
  endtask

  // Block position is a triangle wave over completed steps.
  function automatic int tri_left(int t);
    int k, r, p;
    r = COLS - m_width;
    if (r <= 0) return 0;
    k = (t - m_entry) / m_period;
    p = k % (2*r);
    return (p <= r) ? p : 2*r - p;
  endfunction

  function automatic logic [11:0] m_pix(int h, int v, int t);
    int c, r, l;
    logic [11:0] bg;
    bg = (m_ph == P_LOSE) ? 12'h400 : (m_ph == P_WIN) ? 12'h0F0 : 12'h000;
    if (h < OX || h >= OX + COLS*CELL_PX || v < OY || v >= OY + ROWS*CELL_PX) return bg;
    c = (h - OX) / CELL_PX;
    r = ROWS - 1 - (v - OY) / CELL_PX;
    if ((m_ph == P_MOVE || m_ph == P_TRIM) && r == m_row) begin
      l = (m_ph == P_MOVE) ? tri_left(t) : m_left;
      if (c >= l && c < l + m_width) return 12'hFFF;
    end
    if (c >= m_pl[r] && c < m_pl[r] + m_pw[r]) return 12'hF00;
    return bg;
  endfunction

  task automatic model_step(input bit b, input int h, input int v);
    bit de;
    int l, w, hi;
    m_rgb = m_pix(h, v, m_cyc);
    de = b && !m_btnq && m_armed;
    case (m_ph)
      P_IDLE: if (de) begin
        m_ph = P_MOVE; m_row = 0; m_width = START_W; m_period = TICK_INIT; m_entry = m_cyc + 1;
      end
      P_MOVE: if (de) begin m_left = tri_left(m_cyc); m_ph = P_TRIM; end
      P_TRIM: begin
        if (m_row == 0) begin l = m_left; w = m_width; end
        else begin
          l  = (m_left > m_pl[m_row-1]) ? m_left : m_pl[m_row-1];
          hi = (m_left + m_width < m_pl[m_row-1] + m_pw[m_row-1]) ? m_left + m_width
                                                                   : m_pl[m_row-1] + m_pw[m_row-1];
          w  = hi - l;
        end
        if (w <= 0) m_ph = P_LOSE;
        else begin
          m_pl[m_row] = l; m_pw[m_row] = w;
          m_score = (m_score + w > 255) ? 255 : m_score + w;
          m_ph = P_ADV;
        end
      end
      P_ADV: begin
        m_row++; m_level = m_row;
        if (m_row == ROWS) m_ph = P_WIN;
        else begin
          m_width  = m_pw[m_row-1];
          m_period = (m_period - TICK_DEC < TICK_MIN) ? TICK_MIN : m_period - TICK_DEC;
          m_entry  = m_cyc + 1;
          m_ph     = P_MOVE;
        end
      end
      default: if (de) begin
        for (int i = 0; i < ROWS; i++) begin m_pl[i] = 0; m_pw[i] = 0; end
        m_score = 0; m_level = 0; m_ph = P_IDLE;
      end
    endcase
    m_btnq = b;
    if (!b) m_armed = 1;
    m_cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic int px(int c); return OX + c*CELL_PX; endfunction
  function automatic int py(int r); return OY + (ROWS-1-r)*CELL_PX; endfunction

  task automatic cyc(input bit b, input int h, input int v);
    btn_drop = b; hCount = h[9:0]; vCount = v[9:0];
    @(posedge clk);
    model_step(b, h, v);
    #1;
    chk("rgb", 32'(rgb), 32'(m_rgb));
    chk("score", 32'(score), 32'(m_score));
    chk("level", 32'(level), 32'(m_level));
    chk("game_over", 32'(game_over), 32'(m_ph == P_LOSE));
    chk("win", 32'(win), 32'(m_ph == P_WIN));
  endtask

  task automatic do_reset(input bit b);
    rst = 1'b0; btn_drop = b; btn3 = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_game_over", 32'(game_over), 32'h0);
    chk("rst_win", 32'(win), 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic cyc3(input bit b);
    btn3 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit b;
    m_cyc = 0;
    #2;
    do_reset(1'b0);

    // Reset mid-MOVE with the button held high, then a fresh press.
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(1, px(0), py(1));
    chk("pre_rst_white", 32'(rgb), 32'hFFF);
    do_reset(1'b1);
    repeat (10) cyc(1, px(0), py(0));
    chk("no_restart", 32'(rgb), 32'h000);
    cyc(0, px(0), py(0)); cyc(1, px(0), py(0));
    cyc(0, px(0), py(0));
    chk("restart_white", 32'(rgb), 32'hFFF);

    // Bounce with default timing: probe col 3, then col 15, then col 0 of row 0.
    do_reset(1'b0);
    cyc(0, 0, 0); cyc(1, 0, 0);
    for (int k = 0; k < 130; k++) begin
      cyc(0, px((k < 30) ? 3 : (k < 100) ? 15 : 0), py(0));
      if (k == 19)  chk("bounce_l3_col3", 32'(rgb), 32'hFFF);
      if (k == 20)  chk("empty_move_px", 32'(rgb), 32'h000);
      if (k == 59)  chk("bounce_l11_col15", 32'(rgb), 32'h000);
      if (k == 60)  chk("bounce_l12_col15", 32'(rgb), 32'hFFF);
      if (k == 64)  chk("bounce_l12_hold", 32'(rgb), 32'hFFF);
      if (k == 65)  chk("bounce_back_l11", 32'(rgb), 32'h000);
      if (k == 119) chk("bounce_l1_col0", 32'(rgb), 32'h000);
      if (k == 124) chk("bounce_l0_col0", 32'(rgb), 32'hFFF);
      if (k == 125) chk("bounce_turn_l1", 32'(rgb), 32'h000);
    end

    // Partial overlap: row 0 at left 3, row 1 at left 5.
    do_reset(1'b0);
    cyc(0, 0, 0); cyc(1, 0, 0);
    repeat (15) cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("po_score", 32'(score), 32'd6);
    cyc(0, 0, 0);
    chk("po_level", 32'(level), 32'd2);
    cyc(0, px(1), py(2)); chk("po_new_w_in", 32'(rgb), 32'hFFF);
    cyc(0, px(2), py(2)); chk("po_new_w_out", 32'(rgb), 32'h000);
    cyc(0, px(5), py(1)); chk("po_row1_c5", 32'(rgb), 32'hF00);
    cyc(0, px(4), py(1)); chk("po_row1_c4", 32'(rgb), 32'h000);
    cyc(0, px(6), py(1)); chk("po_row1_c6", 32'(rgb), 32'hF00);
    cyc(0, px(7), py(1)); chk("po_row1_c7", 32'(rgb), 32'h000);
    cyc(0, 144 + 3*40, 35 + 9*40); chk("pixel_f00", 32'(rgb), 32'hF00);

    // No overlap: row 0 at {0,4}, row 1 at left 4.
    do_reset(1'b0);
    cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 0); cyc(0, 0, 0);
    repeat (16) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("no_game_over", 32'(game_over), 32'd1);
    chk("no_score", 32'(score), 32'd4);
    cyc(0, px(0), py(0)); chk("lose_row0_kept", 32'(rgb), 32'hF00);
    cyc(0, px(4), py(1)); chk("lose_bg", 32'(rgb), 32'h400);
    cyc(1, 0, 0);
    chk("lose_clear_go", 32'(game_over), 32'd0);
    chk("lose_clear_score", 32'(score), 32'd0);
    cyc(0, px(0), py(0)); chk("lose_clear_rows", 32'(rgb), 32'h000);

    // Random button and pixel traffic against the model.
    b = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) b = ~b;
      cyc(b, int'($urandom_range(130, 800)), int'($urandom_range(20, 440)));
    end

    // Win and speed-up on the ROWS=3, TICK_INIT=3 instance (periods 3,2,1).
    do_reset(1'b0);
    cyc3(0); cyc3(1);
    repeat (6) cyc3(0);
    cyc3(1); cyc3(0);
    chk("w3_score_r0", 32'(score3), 32'd4);
    cyc3(0);
    repeat (4) cyc3(0);
    cyc3(1); cyc3(0);
    chk("w3_score_r1", 32'(score3), 32'd8);
    cyc3(0);
    repeat (2) cyc3(0);
    cyc3(1); cyc3(0);
    chk("w3_score_r2", 32'(score3), 32'd12);
    chk("w3_win_early", 32'(win3), 32'd0);
    cyc3(0);
    chk("w3_win", 32'(win3), 32'd1);
    chk("w3_level", 32'(level3), 32'd3);
    chk("w3_game_over", 32'(go3), 32'd0);
    chk("w3_score", 32'(score3), 32'd12);
    cyc3(0);
    chk("w3_bg", 32'(rgb3), 32'h0F0);
    cyc3(1);
    chk("w3_clear_win", 32'(win3), 32'd0);
    chk("w3_clear_score", 32'(score3), 32'd0);
    chk("w3_clear_level", 32'(level3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/stacker_engine.md
# stacker_engine

Parametrised stacker game core: a block of cells bounces across a grid row, a drop press freezes it, and the part that does not overlap the row below is trimmed off. The game speeds up each level and reports score, win and loss. It sits between the debounced centre button and the VGA timing generator. It renders the playfield from `hCount`/`vCount` and drives pixel colour.

## Interface
- `ROWS`, 10: stack height in rows; reaching it is a win.
- `COLS`, 16: grid columns.
- `START_W`, 4: initial block width in cells (1..COLS).
- `CELL_PX`, 40: cell edge in pixels.
- `ORIGIN_X`, 144: left pixel of column 0.
- `ORIGIN_Y`, 35: top pixel of row ROWS-1.
- `TICK_INIT`, 5: clk cycles per step at level 0 (≥1).
- `TICK_DEC`, 1: period reduction per level.
- `TICK_MIN`, 1: period floor.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `btn_drop` in 1: debounced level; the block acts on the rising edge only.
- `hCount`, `vCount` in 10 each: current pixel position.
- `rgb` out 12: registered pixel colour.
- `score` out 8: sum of surviving widths, saturating at 255.
- `level` out $clog2(ROWS+1): rows completed.
- `game_over` out 1: high in LOSE.
- `win` out 1: high in WIN.

## Operation
- Reset values:
  - State is IDLE.
  - `rgb` = 0, `score` = 0, `level` = 0, `game_over` = 0, `win` = 0.
  - All row entries cleared (width 0); edge-detect register = 0.
- Drop edge: `drop_e = btn_drop & ~btn_q`, where `btn_q` is `btn_drop` registered each cycle.
- IDLE
  - On `drop_e`: row = 0, left = 0, width = START_W, dir = right, period = TICK_INIT, tick = 0. Go to MOVE.
- MOVE
  - `tick` increments; when `tick == period-1` it goes to 0 and the block takes a step.
  - Step, dir right:
    - If left+width < COLS, left += 1.
    - Otherwise dir = left, and left -= 1 if left > 0.
  - Step, dir left: mirror image (at left = 0, dir = right and left += 1 if left+width < COLS).
  - If width == COLS, the block never moves.
  - `drop_e` in MOVE goes to TRIM. It takes priority over a step in the same cycle, and that step is discarded.
- TRIM (1 cycle)
  - Row 0: store {left, width} unchanged.
  - Otherwise, against row r-1 {pl, pw}:
    - lo = max(left, pl); hi = min(left+width, pl+pw).
    - If hi ≤ lo: go to LOSE; the row is not stored.
    - Else store {lo, hi-lo}.
  - Whenever a row is stored, `score` += stored width (saturating).
- ADVANCE (1 cycle)
  - row += 1 and `level` = row.
  - If row == ROWS: go to WIN.
  - Else: left = 0, width = stored width, dir = right, tick = 0, period = max(period-TICK_DEC, TICK_MIN). Go to MOVE.
- LOSE / WIN
  - Hold the board and score.
  - On `drop_e`: clear all rows, `score`, `level`, `game_over` and `win`. Go to IDLE.
- Arithmetic:
  - Column indices are $clog2(COLS+1) bits; the left+width sum is computed one bit wider.
  - Pixel comparisons use 11-bit sums so nothing wraps.
- Rendering (combinational, then registered into `rgb`):
  - Row r occupies y ∈ [ORIGIN_Y+(ROWS-1-r)·CELL_PX, +CELL_PX).
  - Column c occupies x ∈ [ORIGIN_X+c·CELL_PX, +CELL_PX).
  - Active row in MOVE/TRIM: pixels in [left, left+width) are WHITE (FFF).
  - Stored rows: cells in [l, l+w) are RED (F00).
  - Everything else is background: BLACK in IDLE/MOVE, 400 in LOSE, 0F0 in WIN.
  - The active row overrides stored content.

## Timing
- `rgb` has 1-cycle latency from `hCount`/`vCount`.
- Drop latency:
  - `btn_drop` rises at cycle n; `drop_e` is seen at n.
  - TRIM occupies n+1 and ADVANCE n+2.
  - MOVE resumes at n+3 with the new width visible.
  - `score` updates at the end of TRIM (visible at n+2).
- `game_over` rises in the cycle after TRIM detects no overlap; `win` rises in the cycle after ADVANCE reaches ROWS.
- `btn_drop` held high produces exactly one `drop_e`. Presses during TRIM/ADVANCE are ignored.
- Reset asserted in any state: all outputs return to reset values immediately (async). The first `drop_e` after release must be a fresh rising edge.

## Test plan
- Reset mid-MOVE with `btn_drop` held high:
  - `rgb` = 0 and state is IDLE immediately.
  - No start until `btn_drop` falls and rises again.
- Bounce, defaults: start, no drop.
  - left goes 0→12 in steps every 5 cycles, then 11, …, 0, then 1.
  - Step cycles are exact multiples of 5 after MOVE entry.
- Partial overlap:
  - Row 0 dropped at left = 3 (width 4); row 1 dropped at left = 5.
  - Row 1 stores {5, 2}; score = 6; level = 2; new block width 2.
- No overlap:
  - Row 0 at {0, 4}; row 1 dropped at left = 4.
  - `game_over` = 1, score = 4, rows unchanged; the next drop edge clears to IDLE.
- Win and speed-up with ROWS = 3, TICK_INIT = 3:
  - Aligned drops give periods 3, 2, 1.
  - `win` = 1, score = 12, level = 3.
- Pixel check:
  - hCount = 144+3·40, vCount = 35+9·40 with row 0 stored {3, 4} gives `rgb` = F00 one cycle later.
  - The same point with empty rows in MOVE gives 000.
